pll_reset_ctrl: RTL and testbench
=================================

Name: pll_reset_ctrl

Overview:
- Sits directly downstream of the 96 MHz system PLL and consumes its lock indication.
- Synchronises and qualifies the lock, holds the system reset until lock has been stable for a programmable time, and re-asserts reset on lock loss.
- Once running, generates the fabric clock-enable strobe and a 1 us tick used by USB/LED logic.
- Counts lock-loss events for debug.

Parameters:
- STABLE_CYCLES, 4096, consecutive synchronised-lock cycles required before reset release; must be >= 2.
- CE_DIV, 2, clock-enable strobe period in clk cycles; gives 48 MHz at 96 MHz clk; must be >= 2.
- TICK_DIV, 96, tick strobe period in clk cycles; gives 1 us at 96 MHz; must be >= 2.

Ports:
- clk  input  1  96 MHz PLL output clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset (power-on / external).
- pll_locked  input  1  raw PLL lock; asynchronous to clk; may glitch.
- rst_out  output  1  active-high synchronous system reset for downstream logic.
- ready  output  1  high exactly when rst_out is low.
- ce_out  output  1  one-cycle enable pulse every CE_DIV cycles.
- tick_out  output  1  one-cycle pulse every TICK_DIV cycles.
- loss_count  output  8  number of lock losses while in RUN; saturating.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values (rst=1, applied asynchronously):
  - state RESET, rst_out=1, ready=0, ce_out=0, tick_out=0, loss_count=0.
  - Both sync flops = 0; all counters = 0.
- Synchroniser: two-flop chain on pll_locked produces locked_s. locked_s goes high 2 edges after the first edge sampling pll_locked=1.
- All outputs are registered; none is combinational from inputs.
- FSM:
  - RESET: on the first edge after rst deasserts, go to WAIT. rst_out stays 1 for at least that edge.
  - WAIT: stab counter held at 0. If locked_s=1, go to STABLE with count 0.
  - STABLE: if locked_s=0, go to WAIT and clear the count; this is not a loss event. Otherwise, if count==STABLE_CYCLES-1, go to RUN; else count+1.
  - RUN: rst_out=0, ready=1. If locked_s=0, go to WAIT: rst_out=1 and ready=0 from that edge, loss_count+1, saturating at 255.
- Release latency: pll_locked first sampled high at edge k with no dropout → rst_out low after edge k+STABLE_CYCLES+2.
- Lock dropout latency: in RUN, pll_locked low sampled at edge k → rst_out high after edge k+2.
- Stab counter width: clog2(STABLE_CYCLES); no wrap is possible.
- Strobes:
  - Divider counters are held at 0 and ce_out/tick_out forced to 0 outside RUN.
  - In RUN, each counter counts modulo its DIV.
  - The first pulse appears in the DIV-th cycle of RUN; thereafter pulses are exactly DIV cycles apart, one cycle wide.
  - Counters restart from 0 on every RUN entry.
  - ce_out and tick_out are independent; coincident pulses are allowed.
- Glitches: a lock glitch shorter than 1 cycle may or may not be seen. Any seen low in STABLE restarts qualification in full.
- rst asserted in any state: immediate asynchronous return to reset values, including loss_count.
- Release of rst while pll_locked is already high: normal sequence; release latency is measured from the first sampling edge after rst deasserts.

Test Plan:
- STABLE_CYCLES=8, CE_DIV=2, TICK_DIV=96. Power-on: rst high 5 cycles, pll_locked high from start → rst_out falls exactly 10 edges after the first post-reset sampling edge; ready rises on the same edge; loss_count=0.
- pll_locked low for 3 cycles mid-STABLE (after 5 qualified cycles) → qualification restarts; rst_out falls 10 edges after lock returns; loss_count stays 0.
- In RUN, drop pll_locked for 4 cycles → rst_out high 2 edges later; strobes 0 while not in RUN; loss_count=1; re-release after the full 8-cycle qualification.
- Strobe check over 1000 RUN cycles:
  - ce_out pulses every 2 cycles, first in RUN cycle 2.
  - tick_out pulses every 96 cycles, first in RUN cycle 96.
  - Each is high exactly one cycle.
- 260 lock-loss events in RUN → loss_count saturates at 255 and does not wrap.
- Assert rst asynchronously between clk edges while in RUN → all outputs take reset values immediately, without waiting for a clk edge; loss_count=0; normal re-qualification after rst deasserts.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// PLL lock qualifier and system reset generator. It holds reset until the lock
// has been stable long enough, then produces the fabric clock enable and a 1 us tick.
module pll_reset_ctrl #(
  parameter int STABLE_CYCLES = 4096,
  parameter int CE_DIV        = 2,
  parameter int TICK_DIV      = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       rst_out,
  output logic       ready,
  output logic       ce_out,
  output logic       tick_out,
  output logic [7:0] loss_count
);

  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET,
    S_WAIT,
    S_STABLE,
    S_RUN
  } state_t;

  state_t            state_q;
  logic              sync1_q;
  logic              sync2_q;
  logic [STAB_W-1:0] stab_cnt_q;
  logic              rst_out_q;
  logic              ready_q;
  logic [7:0]        loss_count_q;
  logic              run_hold_d;
  logic [1:0]        strobe_w;

  // pll_locked is asynchronous to clk, so it passes through two flops before anything uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RESET;
      stab_cnt_q   <= '0;
      rst_out_q    <= 1'b1;
      ready_q      <= 1'b0;
      loss_count_q <= 8'd0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          stab_cnt_q <= '0;
          if (sync2_q) begin
            state_q <= S_STABLE;
          end
        end
        S_STABLE: begin
          if (!sync2_q) begin
            state_q    <= S_WAIT;
            stab_cnt_q <= '0;
          end else if (stab_cnt_q == STAB_LAST) begin
            state_q   <= S_RUN;
            rst_out_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            stab_cnt_q <= stab_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!sync2_q) begin
            state_q    <= S_WAIT;
            stab_cnt_q <= '0;
            rst_out_q  <= 1'b1;
            ready_q    <= 1'b0;
            if (loss_count_q != 8'hFF) begin
              loss_count_q <= loss_count_q + 8'd1;
            end
          end
        end
        default: begin
          state_q   <= S_RESET;
          rst_out_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // True only on edges that keep the FSM in RUN. The dividers therefore clear on the exit edge itself.
  assign run_hold_d = (state_q == S_RUN) && sync2_q;

  // Divider 0 drives ce_out and divider 1 drives tick_out.
  // Each pulse is registered one count early, so it lands in the DIV-th RUN cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_div
      localparam int DIV = (gi == 0) ? CE_DIV : TICK_DIV;
      localparam int W   = $clog2(DIV);
      localparam logic [W-1:0] LAST = W'(DIV - 1);
      localparam logic [W-1:0] PRE  = W'(DIV - 2);

      logic [W-1:0] cnt_q;
      logic         pulse_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end else if (run_hold_d) begin
          pulse_q <= (cnt_q == PRE);
          cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end else begin
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end
      end

      assign strobe_w[gi] = pulse_q;
    end
  endgenerate

  assign rst_out    = rst_out_q;
  assign ready      = ready_q;
  assign ce_out     = strobe_w[0];
  assign tick_out   = strobe_w[1];
  assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with STABLE_CYCLES=8, CE_DIV=2 and TICK_DIV=96.
module tb_pll_reset_ctrl;

  localparam int STABLE = 8;
  localparam int CE_D   = 2;
  localparam int TICK_D = 96;
  localparam int REL    = STABLE + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       rst_out;
  logic       ready;
  logic       ce_out;
  logic       tick_out;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;

  pll_reset_ctrl #(
    .STABLE_CYCLES(STABLE),
    .CE_DIV(CE_D),
    .TICK_DIV(TICK_D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .rst_out(rst_out),
    .ready(ready),
    .ce_out(ce_out),
    .tick_out(tick_out),
    .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // This task starts just before the first edge that samples the lock high.
  // rst_out must fall exactly REL edges after that edge, and the strobes stay quiet until then.
  task automatic requal(input string tag);
    step();
    chk({tag, "_k0_rst"}, rst_out, 1);
    for (int i = 1; i <= REL; i++) begin
      step();
      chk({tag, "_rst"}, rst_out, (i < REL) ? 1 : 0);
      chk({tag, "_rdy"}, ready, (i < REL) ? 0 : 1);
      if (i < REL) begin
        chk({tag, "_ce"}, ce_out, 0);
        chk({tag, "_tick"}, tick_out, 0);
      end
    end
  endtask

  // Called while in RUN. The lock is low for low_edges sampling edges and then returns.
  task automatic lose_lock(input string tag, input int low_edges, input int exp_loss);
    pll_locked = 1'b0;
    step();
    chk({tag, "_k0"}, rst_out, 0);
    step();
    chk({tag, "_k1"}, rst_out, 0);
    step();
    chk({tag, "_k2_rst"}, rst_out, 1);
    chk({tag, "_k2_rdy"}, ready, 0);
    chk({tag, "_k2_ce"}, ce_out, 0);
    chk({tag, "_k2_tick"}, tick_out, 0);
    chk({tag, "_loss"}, loss_count, exp_loss);
    for (int i = 3; i < low_edges; i++) begin
      step();
      chk({tag, "_low_rst"}, rst_out, 1);
      chk({tag, "_low_ce"}, ce_out, 0);
    end
    pll_locked = 1'b1;
    requal({tag, "_req"});
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b1;

    // Power-on: reset held for 5 edges with the lock already high.
    for (int i = 0; i < 5; i++) step();
    chk("por_rst", rst_out, 1);
    chk("por_rdy", ready, 0);
    chk("por_ce", ce_out, 0);
    chk("por_tick", tick_out, 0);
    chk("por_loss", loss_count, 0);
    rst = 1'b0;
    requal("por");
    chk("por_loss_after", loss_count, 0);
    $display("release after power-on: rst_out=%0b ready=%0b", rst_out, ready);

    // Strobe cadence over 1000 RUN cycles. The bench is in RUN cycle 1 here.
    for (int j = 1; j <= 1000; j++) begin
      chk("ce_cadence", ce_out, (j % CE_D == 0) ? 1 : 0);
      chk("tick_cadence", tick_out, (j % TICK_D == 0) ? 1 : 0);
      step();
    end
    $display("strobe cadence over 1000 RUN cycles done");

    // The lock drops for 4 cycles while in RUN.
    lose_lock("drop4", 4, 1);
    $display("lock dropout: loss_count=%0d", loss_count);

    // Further losses push the counter to saturation.
    for (int i = 2; i <= 260; i++) begin
      lose_lock("sat", 3, (i > 255) ? 255 : i);
    end
    chk("sat_final", loss_count, 255);
    $display("after 260 losses: loss_count=%0d", loss_count);

    // Apply rst between edges while ce_out is high.
    step();
    chk("pre_async_ce", ce_out, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", rst_out, 1);
    chk("async_rdy", ready, 0);
    chk("async_ce", ce_out, 0);
    chk("async_tick", tick_out, 0);
    chk("async_loss", loss_count, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("async_hold_rst", rst_out, 1);
    end
    rst = 1'b0;
    requal("async_req");
    chk("async_req_loss", loss_count, 0);
    $display("async reset and requalify: loss_count=%0d", loss_count);

    // The lock glitches during STABLE. Qualification restarts, and this is not a loss.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("glitch_pre_rst", rst_out, 1);
    end
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("glitch_low_rst", rst_out, 1);
    end
    pll_locked = 1'b1;
    requal("glitch_req");
    chk("glitch_loss", loss_count, 0);
    $display("stable glitch requalify: rst_out=%0b loss_count=%0d", rst_out, loss_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
